snake_vga_sync: RTL and testbench

Timing generator for the snake game's 800x600@60 Hz VGA output, driven by the 40 MHz pixel clock. It produces HSYNC/VSYNC, the active-video qualifier, and the current pixel's column and row addresses. These feed every downstream screen-drawing stage (start, game and end screen controllers) and the colour mux. It also emits a one-cycle frame tick that the game logic uses to pace snake movement.

---
 rtl/snake_vga_pkg.sv | 22 ++
 rtl/vga_axis_counter.sv | 29 ++
 rtl/snake_vga_sync.sv | 87 ++++++++
 tb/tb_snake_vga_sync.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_vga_pkg.sv
// Shared 800x600@60 Hz timing constants for the snake game's VGA path.
// Screen controllers import this for their window checks.
package snake_vga_pkg;

  localparam int H_ACTIVE = 800;
  localparam int H_FP     = 40;
  localparam int H_SYNC   = 128;
  localparam int H_BP     = 88;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 600;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 4;
  localparam int V_BP     = 23;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic SYNC_POL = 1'b1;

  localparam int H_W = 11;
  localparam int V_W = 10;

endpackage

// File: rtl/vga_axis_counter.sv
// Free-running modulo-TOTAL counter for one VGA axis.
// The counter advances on en and flags its terminal count on last.
module vga_axis_counter #(
  parameter int TOTAL = 1056,
  parameter int W     = 11
) (
  input  logic         CLK_40M,
  input  logic         RST,
  input  logic         en,
  input  logic         clear,
  output logic [W-1:0] cnt,
  output logic         last
);

  localparam logic [W-1:0] LAST_VAL = W'(TOTAL - 1);

  assign last = (cnt == LAST_VAL);

  always_ff @(posedge CLK_40M or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= last ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/snake_vga_sync.sv
// VGA timing generator: registered HSYNC/VSYNC, active qualifier, pixel
// address and a one-cycle frame tick at the start of vertical blanking.
module snake_vga_sync #(
  parameter int   H_ACTIVE = snake_vga_pkg::H_ACTIVE,
  parameter int   H_FP     = snake_vga_pkg::H_FP,
  parameter int   H_SYNC   = snake_vga_pkg::H_SYNC,
  parameter int   H_BP     = snake_vga_pkg::H_BP,
  parameter int   V_ACTIVE = snake_vga_pkg::V_ACTIVE,
  parameter int   V_FP     = snake_vga_pkg::V_FP,
  parameter int   V_SYNC   = snake_vga_pkg::V_SYNC,
  parameter int   V_BP     = snake_vga_pkg::V_BP,
  parameter logic SYNC_POL = snake_vga_pkg::SYNC_POL
) (
  input  logic        CLK_40M,
  input  logic        RST,
  output logic        HSYNC_Sig,
  output logic        VSYNC_Sig,
  output logic        Ready_Sig,
  output logic [10:0] Column_add,
  output logic [10:0] Row_add,
  output logic        Frame_tick
);
  import snake_vga_pkg::*;

  localparam int LINE_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int FRAME_LINES = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [H_W-1:0] H_ACT_END = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0] HS_FIRST  = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] HS_LAST   = H_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [V_W-1:0] V_ACT_END = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0] VS_FIRST  = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] VS_LAST   = V_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [H_W-1:0] h_cnt;
  logic [V_W-1:0] v_cnt;
  logic           h_last;
  logic           v_last_unused;
  logic           active;
  logic           hs;
  logic           vs;
  logic           tick;

  vga_axis_counter #(.TOTAL(LINE_TOTAL), .W(H_W)) u_h_cnt (
    .CLK_40M (CLK_40M),
    .RST     (RST),
    .en      (1'b1),
    .clear   (1'b0),
    .cnt     (h_cnt),
    .last    (h_last)
  );

  // Line counter steps once per completed line and wraps with the last pixel.
  vga_axis_counter #(.TOTAL(FRAME_LINES), .W(V_W)) u_v_cnt (
    .CLK_40M (CLK_40M),
    .RST     (RST),
    .en      (h_last),
    .clear   (1'b0),
    .cnt     (v_cnt),
    .last    (v_last_unused)
  );

  assign active = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
  assign hs     = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
  assign vs     = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
  assign tick   = (v_cnt == V_ACT_END) && (h_cnt == '0);

  // All outputs share one register stage so they stay mutually aligned.
  always_ff @(posedge CLK_40M or posedge RST) begin
    if (RST) begin
      HSYNC_Sig  <= ~SYNC_POL;
      VSYNC_Sig  <= ~SYNC_POL;
      Ready_Sig  <= 1'b0;
      Column_add <= '0;
      Row_add    <= '0;
      Frame_tick <= 1'b0;
    end else begin
      HSYNC_Sig  <= hs ? SYNC_POL : ~SYNC_POL;
      VSYNC_Sig  <= vs ? SYNC_POL : ~SYNC_POL;
      Ready_Sig  <= active;
      Column_add <= active ? 11'(h_cnt) : 11'd0;
      Row_add    <= active ? 11'(v_cnt) : 11'd0;
      Frame_tick <= tick;
    end
  end

endmodule

// File: tb/tb_snake_vga_sync.sv
// Bench for snake_vga_sync: full-size instance for reset and line timing,
// a small inverted-polarity instance for frame, tick, wrap and mid-frame reset.
module tb_snake_vga_sync;

  localparam int M_HA = 800, M_HF = 40, M_HS = 128, M_HB = 88;
  localparam int M_VA = 600, M_VF = 1,  M_VS = 4,   M_VB = 23;
  localparam int M_HT = M_HA + M_HF + M_HS + M_HB;
  localparam int M_VT = M_VA + M_VF + M_VS + M_VB;

  localparam int S_HA = 16, S_HF = 2, S_HS = 4, S_HB = 3;
  localparam int S_VA = 6,  S_VF = 1, S_VS = 2, S_VB = 3;
  localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
  localparam int S_VT = S_VA + S_VF + S_VS + S_VB;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        rdy;
    logic [10:0] col;
    logic [10:0] row;
    logic        tick;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_m = 1'b1;
  logic        rst_s = 1'b1;
  logic        hs_m, vs_m, rdy_m, tick_m;
  logic [10:0] col_m, row_m;
  logic        hs_s, vs_s, rdy_s, tick_s;
  logic [10:0] col_s, row_s;

  int n_cmp = 0;
  int n_err = 0;

  obs_t q_m[$];
  obs_t q_s[$];
  int   mh, mv, sh, sv;

  always #5 clk = ~clk;

  snake_vga_sync u_dut (
    .CLK_40M    (clk),
    .RST        (rst_m),
    .HSYNC_Sig  (hs_m),
    .VSYNC_Sig  (vs_m),
    .Ready_Sig  (rdy_m),
    .Column_add (col_m),
    .Row_add    (row_m),
    .Frame_tick (tick_m)
  );

  snake_vga_sync #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
    .SYNC_POL(1'b0)
  ) u_small (
    .CLK_40M    (clk),
    .RST        (rst_s),
    .HSYNC_Sig  (hs_s),
    .VSYNC_Sig  (vs_s),
    .Ready_Sig  (rdy_s),
    .Column_add (col_s),
    .Row_add    (row_s),
    .Frame_tick (tick_s)
  );

  function automatic obs_t expect_out(input int h, input int v, input int ha, input int hf,
                                      input int hsw, input int va, input int vf, input int vsw,
                                      input logic pol);
    obs_t e;
    bit   act;
    act    = (h < ha) && (v < va);
    e.hs   = (h >= ha + hf && h < ha + hf + hsw) ? pol : ~pol;
    e.vs   = (v >= va + vf && v < va + vf + vsw) ? pol : ~pol;
    e.rdy  = act;
    e.col  = act ? 11'(h) : 11'd0;
    e.row  = act ? 11'(v) : 11'd0;
    e.tick = (v == va) && (h == 0);
    return e;
  endfunction

  // Reference counters: each clock pushes the expected decode of the
  // pre-edge state, which the DUT shows after that edge.
  always @(posedge clk or posedge rst_m) begin
    if (rst_m) begin
      mh = 0; mv = 0; q_m.delete();
    end else begin
      q_m.push_back(expect_out(mh, mv, M_HA, M_HF, M_HS, M_VA, M_VF, M_VS, 1'b1));
      mh++;
      if (mh == M_HT) begin mh = 0; mv++; if (mv == M_VT) mv = 0; end
    end
  end

  always @(posedge clk or posedge rst_s) begin
    if (rst_s) begin
      sh = 0; sv = 0; q_s.delete();
    end else begin
      q_s.push_back(expect_out(sh, sv, S_HA, S_HF, S_HS, S_VA, S_VF, S_VS, 1'b0));
      sh++;
      if (sh == S_HT) begin sh = 0; sv++; if (sv == S_VT) sv = 0; end
    end
  end

  task automatic test_reset();
    obs_t act, exp;
    rst_m = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++;
    act = {hs_m, vs_m, rdy_m, col_m, row_m, tick_m};
    if (act !== 25'd0) begin
      n_err++; $display("FAIL reset_values: got %h want %h", act, 25'd0);
    end
    rst_m = 1'b0;
    @(negedge clk);
    act = {hs_m, vs_m, rdy_m, col_m, row_m, tick_m};
    n_cmp++;
    if (q_m.size() == 0) begin
      n_err++; $display("FAIL reset_release_sb: scoreboard empty, got %h", act);
    end else begin
      exp = q_m.pop_front();
      if (act !== exp) begin n_err++; $display("FAIL reset_release_sb: got %h want %h", act, exp); end
    end
    n_cmp++;
    if ({hs_m, vs_m, rdy_m, col_m, row_m} !== {1'b0, 1'b0, 1'b1, 11'd0, 11'd0}) begin
      n_err++;
      $display("FAIL first_output: got hs=%b vs=%b rdy=%b col=%0d row=%0d want 0 0 1 0 0",
               hs_m, vs_m, rdy_m, col_m, row_m);
    end
  endtask

  task automatic test_line_timing();
    obs_t act, exp;
    logic prev_rdy = 1'b1, prev_hs = 1'b0;
    logic [10:0] prev_col = 11'd0;
    int rise = -1, fall = -1, hs_rise = -1, n_fall = 0;
    for (int c = 1; c <= 3 * M_HT + 8; c++) begin
      @(negedge clk);
      act = {hs_m, vs_m, rdy_m, col_m, row_m, tick_m};
      n_cmp++;
      if (q_m.size() == 0) begin
        n_err++; $display("FAIL line_sb @%0d: scoreboard empty, got %h", c, act);
      end else begin
        exp = q_m.pop_front();
        if (act !== exp) begin n_err++; $display("FAIL line_sb @%0d: got %h want %h", c, act, exp); end
      end
      if (rdy_m && !prev_rdy) begin
        if (rise >= 0) begin
          n_cmp++;
          if (c - rise != M_HT) begin n_err++; $display("FAIL line_period: got %0d want %0d", c - rise, M_HT); end
        end
        rise = c;
      end
      if (!rdy_m && prev_rdy) begin
        n_fall++;
        if (rise >= 0) begin
          n_cmp++;
          if (c - rise != M_HA) begin n_err++; $display("FAIL ready_width: got %0d want %0d", c - rise, M_HA); end
        end
        n_cmp++;
        if (prev_col != 11'(M_HA - 1)) begin n_err++; $display("FAIL last_column: got %0d want %0d", prev_col, M_HA - 1); end
        fall = c;
      end
      if (rdy_m && prev_rdy) begin
        n_cmp++;
        if (col_m != prev_col + 11'd1) begin n_err++; $display("FAIL column_step: got %0d want %0d", col_m, prev_col + 11'd1); end
      end
      if (hs_m && !prev_hs) begin
        n_cmp++;
        if (c - fall != M_HF) begin n_err++; $display("FAIL hsync_start: got %0d want %0d", c - fall, M_HF); end
        hs_rise = c;
      end
      if (!hs_m && prev_hs) begin
        n_cmp++;
        if (c - hs_rise != M_HS) begin n_err++; $display("FAIL hsync_width: got %0d want %0d", c - hs_rise, M_HS); end
      end
      prev_rdy = rdy_m; prev_hs = hs_m; prev_col = col_m;
    end
    n_cmp++;
    if (n_fall != 3) begin n_err++; $display("FAIL ready_fall_count: got %0d want 3", n_fall); end
    rst_m = 1'b1;
  endtask

  task automatic test_frame_timing();
    obs_t act, exp;
    logic prev_vs = 1'b1;
    int frame_start = -1, vs_fall = -1, last_tick = -1, n_tick = 0, n_vs = 0, max_row = 0;
    rst_s = 1'b1;
    repeat (2) @(negedge clk);
    rst_s = 1'b0;
    for (int c = 0; c < 2 * S_HT * S_VT + 5; c++) begin
      @(negedge clk);
      act = {hs_s, vs_s, rdy_s, col_s, row_s, tick_s};
      n_cmp++;
      if (q_s.size() == 0) begin
        n_err++; $display("FAIL frame_sb @%0d: scoreboard empty, got %h", c, act);
      end else begin
        exp = q_s.pop_front();
        if (act !== exp) begin n_err++; $display("FAIL frame_sb @%0d: got %h want %h", c, act, exp); end
      end
      if (rdy_s && col_s == 11'd0 && row_s == 11'd0) begin
        if (frame_start >= 0) begin
          n_cmp++;
          if (c - frame_start != S_HT * S_VT) begin
            n_err++; $display("FAIL frame_period: got %0d want %0d", c - frame_start, S_HT * S_VT);
          end
        end
        frame_start = c;
      end
      if (rdy_s && int'(row_s) > max_row) max_row = int'(row_s);
      if (!vs_s && prev_vs) begin
        n_vs++;
        n_cmp++;
        if (c - frame_start != (S_VA + S_VF) * S_HT) begin
          n_err++; $display("FAIL vsync_start: got %0d want %0d", c - frame_start, (S_VA + S_VF) * S_HT);
        end
        vs_fall = c;
      end
      if (vs_s && !prev_vs) begin
        n_cmp++;
        if (c - vs_fall != S_VS * S_HT) begin
          n_err++; $display("FAIL vsync_width: got %0d want %0d", c - vs_fall, S_VS * S_HT);
        end
      end
      if (tick_s) begin
        n_tick++;
        n_cmp++;
        if (rdy_s !== 1'b0 || c - frame_start != S_VA * S_HT) begin
          n_err++; $display("FAIL tick_position: got rdy=%b offset=%0d want rdy=0 offset=%0d",
                            rdy_s, c - frame_start, S_VA * S_HT);
        end
        if (last_tick >= 0) begin
          n_cmp++;
          if (c - last_tick != S_HT * S_VT) begin
            n_err++; $display("FAIL tick_period: got %0d want %0d", c - last_tick, S_HT * S_VT);
          end
        end
        last_tick = c;
      end
      if (c == S_HT * S_VT - 1) begin
        n_cmp++;
        if (rdy_s !== 1'b0 || vs_s !== 1'b1) begin
          n_err++; $display("FAIL wrap_cycle: got rdy=%b vs=%b want rdy=0 vs=1", rdy_s, vs_s);
        end
      end
      prev_vs = vs_s;
    end
    n_cmp++;
    if (n_tick != 2 || n_vs != 2 || max_row != S_VA - 1) begin
      n_err++; $display("FAIL frame_counts: got ticks=%0d vsyncs=%0d max_row=%0d want 2 2 %0d",
                        n_tick, n_vs, max_row, S_VA - 1);
    end
  endtask

  task automatic test_mid_reset();
    obs_t act, exp;
    rst_s = 1'b1;
    @(negedge clk);
    rst_s = 1'b0;
    repeat (3 * S_HT + 8) @(negedge clk);
    n_cmp++;
    if (rdy_s !== 1'b1 || row_s != 11'd3) begin
      n_err++; $display("FAIL pre_reset_position: got rdy=%b row=%0d want rdy=1 row=3", rdy_s, row_s);
    end
    #2 rst_s = 1'b1;
    #1;
    act = {hs_s, vs_s, rdy_s, col_s, row_s, tick_s};
    exp = {1'b1, 1'b1, 1'b0, 11'd0, 11'd0, 1'b0};
    n_cmp++;
    if (act !== exp) begin n_err++; $display("FAIL async_reset: got %h want %h", act, exp); end
    repeat (3) @(negedge clk);
    rst_s = 1'b0;
    for (int c = 0; c < 2 * S_HT; c++) begin
      @(negedge clk);
      act = {hs_s, vs_s, rdy_s, col_s, row_s, tick_s};
      n_cmp++;
      if (q_s.size() == 0) begin
        n_err++; $display("FAIL restart_sb @%0d: scoreboard empty, got %h", c, act);
      end else begin
        exp = q_s.pop_front();
        if (act !== exp) begin n_err++; $display("FAIL restart_sb @%0d: got %h want %h", c, act, exp); end
      end
      if (c == 0) begin
        n_cmp++;
        if ({hs_s, vs_s, rdy_s, col_s, row_s} !== {1'b1, 1'b1, 1'b1, 11'd0, 11'd0}) begin
          n_err++;
          $display("FAIL restart_first: got hs=%b vs=%b rdy=%b col=%0d row=%0d want 1 1 1 0 0",
                   hs_s, vs_s, rdy_s, col_s, row_s);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_line_timing();
    test_frame_timing();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
